riscv_dmem_arbiter: RTL and testbench
=====================================

# riscv_dmem_arbiter

Two-master arbiter for the single-port data memory of the RV32I single-cycle core. It shares the memory between the core load/store port and a debug/bench access port, and uses round-robin priority with an optional locked debug burst. It also routes the one-cycle-latency read data back to whichever master issued the read. It sits between `riscv_singlecycle`'s LSU and the data memory macro.

## Interface
- `XLEN`, default 32: data and address width.
- `MAX_BURST`, default 8: maximum number of consecutive beats a debug burst may hold the memory (range 1..16).

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `core_req_i`  in  1  core access request; held until granted.
- `core_we_i`  in  1  1 = store, 0 = load.
- `core_be_i`  in  4  byte enables.
- `core_addr_i`  in  XLEN  byte address.
- `core_wdata_i`  in  XLEN  store data.
- `core_gnt_o`  out  1  access accepted this cycle.
- `core_stall_o`  out  1  `core_req_i & ~core_gnt_o`.
- `core_rvalid_o`  out  1  load data valid.
- `core_rdata_o`  out  XLEN  load data.
- `dbg_req_i`  in  1  debug access request.
- `dbg_we_i`  in  1  debug write.
- `dbg_addr_i`  in  XLEN  debug byte address.
- `dbg_wdata_i`  in  XLEN  debug write data; always a full word, so byte enables are 4'hF.
- `dbg_len_i`  in  4  burst beats minus one; sampled on the first debug grant.
- `dbg_gnt_o`  out  1  debug access accepted.
- `dbg_rvalid_o`  out  1  debug read data valid.
- `dbg_rdata_o`  out  XLEN  debug read data.
- `mem_en_o`  out  1  memory access strobe.
- `mem_we_o`  out  1  memory write.
- `mem_be_o`  out  4  memory byte enables.
- `mem_addr_o`  out  XLEN  memory address.
- `mem_wdata_o`  out  XLEN  memory write data.
- `mem_rdata_i`  in  XLEN  read data, valid one cycle after `mem_en_o & ~mem_we_o`.

## Operation
- **Priority register `prio_q`.**
  - 0 means core preferred; 1 means debug preferred.
  - Resets to 0.
  - After any granted beat it is set to favour the master that was *not* granted.
- **FSM states:** ARB and DBG_BURST.
- **ARB state.**
  - Only one master requesting: that master is granted.
  - Both requesting: the master selected by `prio_q` is granted.
  - Debug granted with `min(dbg_len_i, MAX_BURST-1)` > 0: load `beat_cnt` with that value and go to DBG_BURST.
- **DBG_BURST state.**
  - Debug is granted every cycle `dbg_req_i` is high, and `beat_cnt` decrements on each such grant.
  - The core is never granted in this state, so `core_stall_o` follows `core_req_i`.
  - The burst ends and the FSM returns to ARB when either:
    - the beat with `beat_cnt == 1` is granted, or
    - `dbg_req_i` is low in a cycle (abort). No grant is issued in the abort cycle.
  - On exit `prio_q` is set to 0 (core preferred).
- **Memory mux.** The `mem_*` outputs carry the granted master's fields; `mem_en_o = core_gnt_o | dbg_gnt_o`. With no grant, all `mem_*` outputs are 0.
- **Read return.**
  - A response register captures `{valid, owner}` for each granted read.
  - The next cycle, `*_rvalid_o` pulses for that owner only and `*_rdata_o = mem_rdata_i`.
  - When not valid, `rdata` is 0.
  - Writes produce no rvalid.
- `core_gnt_o` and `dbg_gnt_o` are never high together.

## Timing
- Grants are combinational from the requests and registered state: a request is granted in the same cycle it is presented, with zero added latency.
- Read latency is 1 cycle from grant to `rvalid`. Back-to-back reads from either master give `rvalid` on consecutive cycles.
- Reset values (asserted in the cycle after `rst_i` is sampled high):
  - State: ARB, `prio_q` = 0, `beat_cnt` = 0, response valid = 0.
  - All `*_gnt_o`, `*_rvalid_o`, `*_rdata_o` and `mem_*` outputs = 0.
  - While `rst_i` is high the grants are forced to 0.
- Reset in the middle of a burst or while a read is outstanding: the burst is dropped and the pending `rvalid` is suppressed (it is not delivered after reset).
- A `dbg_len_i` value above `MAX_BURST-1` is clamped. `dbg_len_i` = 0 is a single beat with no state change.
- Worst-case core wait is `MAX_BURST` cycles after a debug burst starts, plus 0 cycles when debug is idle.

## Test plan
- **Core only.** Core read to 0x80000010, memory returns 0xDEADBEEF. Required:
  - `core_gnt_o` = 1 in cycle N.
  - `core_rvalid_o` = 1 with `core_rdata_o` = 0xDEADBEEF in cycle N+1.
  - `dbg_rvalid_o` = 0.
- **Contention alternation.** Both masters request continuously for 4 cycles after reset. Required:
  - Grant sequence core, dbg, core, dbg.
  - `mem_addr_o` follows the granted master's address.
- **Burst lock.** Debug request with `dbg_len_i` = 3 while the core also requests. Required:
  - Debug is granted 4 consecutive cycles while `core_stall_o` = 1.
  - The core is granted in the 5th cycle.
- **Clamp and abort.**
  - With `MAX_BURST` = 8 and `dbg_len_i` = 15: exactly 8 debug beats.
  - Separately, dropping `dbg_req_i` after 2 beats of a `dbg_len_i` = 5 burst: FSM returns to ARB and the core is granted the next cycle.
- **Write path.** Core store with `be` = 4'b0011 and data 0x0000ABCD. Required:
  - `mem_we_o` = 1, `mem_be_o` = 4'b0011, `mem_wdata_o` = 0x0000ABCD.
  - No `rvalid` on either port.
- **Reset mid-read.** Debug read granted, then `rst_i` = 1 in the next cycle. Required:
  - `dbg_rvalid_o` stays 0.
  - After reset, a simultaneous request is granted to the core first.

Source files
------------

// File: rtl/riscv_dmem_arbiter.sv
// Two-master arbiter for the data memory: core LSU vs debug port, round-robin
// priority, locked debug bursts, and one-cycle read-data return routing.
module riscv_dmem_arbiter #(
    parameter int XLEN      = 32,
    parameter int MAX_BURST = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            core_req_i,
    input  logic            core_we_i,
    input  logic [3:0]      core_be_i,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic [XLEN-1:0] core_wdata_i,
    output logic            core_gnt_o,
    output logic            core_stall_o,
    output logic            core_rvalid_o,
    output logic [XLEN-1:0] core_rdata_o,

    input  logic            dbg_req_i,
    input  logic            dbg_we_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    input  logic [XLEN-1:0] dbg_wdata_i,
    input  logic [3:0]      dbg_len_i,
    output logic            dbg_gnt_o,
    output logic            dbg_rvalid_o,
    output logic [XLEN-1:0] dbg_rdata_o,

    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic {
        ARB       = 1'b0,
        DBG_BURST = 1'b1
    } state_t;

    localparam logic [3:0] LEN_MAX = 4'(MAX_BURST - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic        w_prio_nxt;
    logic [3:0]  r_beat_cnt;
    logic [3:0]  w_beat_cnt_nxt;
    logic        r_rsp_vld;
    logic        r_rsp_dbg;
    logic        w_rsp_vld_nxt;
    logic        w_rsp_dbg_nxt;
    logic        w_core_gnt;
    logic        w_dbg_gnt;
    logic [3:0]  w_len_clamp;

    assign w_len_clamp = (dbg_len_i > LEN_MAX) ? LEN_MAX : dbg_len_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ARB;
            r_prio     <= 1'b0;
            r_beat_cnt <= 4'd0;
            r_rsp_vld  <= 1'b0;
            r_rsp_dbg  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio     <= w_prio_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_rsp_vld  <= w_rsp_vld_nxt;
            r_rsp_dbg  <= w_rsp_dbg_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_prio_nxt     = r_prio;
        w_beat_cnt_nxt = r_beat_cnt;
        w_core_gnt     = 1'b0;
        w_dbg_gnt      = 1'b0;

        case (r_state)
            ARB: begin
                if (core_req_i && (!dbg_req_i || !r_prio)) begin
                    w_core_gnt = 1'b1;
                end else if (dbg_req_i) begin
                    w_dbg_gnt = 1'b1;
                end
                // The first beat is issued here; beat_cnt holds the beats still owed.
                if (w_dbg_gnt && (w_len_clamp != 4'd0)) begin
                    w_beat_cnt_nxt = w_len_clamp;
                    w_state_nxt    = DBG_BURST;
                end
            end
            DBG_BURST: begin
                if (dbg_req_i) begin
                    w_dbg_gnt      = 1'b1;
                    w_beat_cnt_nxt = r_beat_cnt - 4'd1;
                    if (r_beat_cnt == 4'd1) begin
                        w_state_nxt = ARB;
                    end
                end else begin
                    w_beat_cnt_nxt = 4'd0;
                    w_state_nxt    = ARB;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase

        if (w_core_gnt) begin
            w_prio_nxt = 1'b1;
        end
        if (w_dbg_gnt) begin
            w_prio_nxt = 1'b0;
        end
        if ((r_state == DBG_BURST) && (w_state_nxt == ARB)) begin
            w_prio_nxt = 1'b0;
        end

        if (rst_i) begin
            w_core_gnt = 1'b0;
            w_dbg_gnt  = 1'b0;
        end
    end

    always_comb begin
        w_rsp_vld_nxt = 1'b0;
        w_rsp_dbg_nxt = 1'b0;
        mem_en_o      = 1'b0;
        mem_we_o      = 1'b0;
        mem_be_o      = 4'h0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;

        if (w_core_gnt) begin
            mem_en_o      = 1'b1;
            mem_we_o      = core_we_i;
            mem_be_o      = core_be_i;
            mem_addr_o    = core_addr_i;
            mem_wdata_o   = core_wdata_i;
            w_rsp_vld_nxt = !core_we_i;
        end else if (w_dbg_gnt) begin
            mem_en_o      = 1'b1;
            mem_we_o      = dbg_we_i;
            mem_be_o      = 4'hF;
            mem_addr_o    = dbg_addr_i;
            mem_wdata_o   = dbg_wdata_i;
            w_rsp_vld_nxt = !dbg_we_i;
            w_rsp_dbg_nxt = 1'b1;
        end
    end

    assign core_gnt_o   = w_core_gnt;
    assign dbg_gnt_o    = w_dbg_gnt;
    assign core_stall_o = core_req_i & ~w_core_gnt;

    // A response captured just before reset must not leak out while reset is held.
    assign core_rvalid_o = r_rsp_vld & ~r_rsp_dbg & ~rst_i;
    assign dbg_rvalid_o  = r_rsp_vld &  r_rsp_dbg & ~rst_i;
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
    assign dbg_rdata_o   = dbg_rvalid_o  ? mem_rdata_i : '0;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Bench for riscv_dmem_arbiter: directed scenarios followed by random traffic,
// all outputs compared each cycle against a transaction-level reference model.
module tb_riscv_dmem_arbiter;

    localparam int XLEN      = 32;
    localparam int MAX_BURST = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            core_req_i, core_we_i;
    logic [3:0]      core_be_i;
    logic [XLEN-1:0] core_addr_i, core_wdata_i;
    logic            core_gnt_o, core_stall_o, core_rvalid_o;
    logic [XLEN-1:0] core_rdata_o;
    logic            dbg_req_i, dbg_we_i;
    logic [XLEN-1:0] dbg_addr_i, dbg_wdata_i;
    logic [3:0]      dbg_len_i;
    logic            dbg_gnt_o, dbg_rvalid_o;
    logic [XLEN-1:0] dbg_rdata_o;
    logic            mem_en_o, mem_we_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    riscv_dmem_arbiter #(.XLEN(XLEN), .MAX_BURST(MAX_BURST)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_gnt_o(core_gnt_o), .core_stall_o(core_stall_o),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_len_i(dbg_len_i),
        .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model: who is favoured, how many locked debug beats remain,
    // and which read (if any) is waiting for its data.
    bit m_prio;
    int m_locked_left;
    bit m_pend_vld, m_pend_dbg;
    bit e_core, e_dbg;

    // Observed values captured at the last check point.
    logic            s_core_gnt, s_dbg_gnt, s_core_stall, s_core_rvalid, s_dbg_rvalid;
    logic            s_mem_en, s_mem_we;
    logic [3:0]      s_mem_be;
    logic [XLEN-1:0] s_core_rdata, s_dbg_rdata, s_mem_addr, s_mem_wdata;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        logic            x_en, x_we, x_crv, x_drv;
        logic [3:0]      x_be;
        logic [XLEN-1:0] x_addr, x_wdata;
        e_core = 1'b0;
        e_dbg  = 1'b0;
        if (!rst_i) begin
            if (m_locked_left > 0) begin
                e_dbg = dbg_req_i;
            end else if (core_req_i && dbg_req_i) begin
                e_dbg  = m_prio;
                e_core = !m_prio;
            end else begin
                e_core = core_req_i;
                e_dbg  = dbg_req_i;
            end
        end
        x_en = e_core | e_dbg;
        x_we = e_core ? core_we_i : (e_dbg ? dbg_we_i : 1'b0);
        x_be = e_core ? core_be_i : (e_dbg ? 4'hF : 4'h0);
        x_addr  = e_core ? core_addr_i  : (e_dbg ? dbg_addr_i  : '0);
        x_wdata = e_core ? core_wdata_i : (e_dbg ? dbg_wdata_i : '0);
        x_crv = m_pend_vld && !m_pend_dbg && !rst_i;
        x_drv = m_pend_vld &&  m_pend_dbg && !rst_i;

        s_core_gnt = core_gnt_o;     s_dbg_gnt = dbg_gnt_o;
        s_core_stall = core_stall_o; s_core_rvalid = core_rvalid_o;
        s_dbg_rvalid = dbg_rvalid_o; s_core_rdata = core_rdata_o;
        s_dbg_rdata = dbg_rdata_o;   s_mem_en = mem_en_o;
        s_mem_we = mem_we_o;         s_mem_be = mem_be_o;
        s_mem_addr = mem_addr_o;     s_mem_wdata = mem_wdata_o;

        chk("core_gnt",    XLEN'(s_core_gnt),    XLEN'(e_core));
        chk("dbg_gnt",     XLEN'(s_dbg_gnt),     XLEN'(e_dbg));
        chk("core_stall",  XLEN'(s_core_stall),  XLEN'(core_req_i && !e_core));
        chk("mem_en",      XLEN'(s_mem_en),      XLEN'(x_en));
        chk("mem_we",      XLEN'(s_mem_we),      XLEN'(x_we));
        chk("mem_be",      XLEN'(s_mem_be),      XLEN'(x_be));
        chk("mem_addr",    s_mem_addr,           x_addr);
        chk("mem_wdata",   s_mem_wdata,          x_wdata);
        chk("core_rvalid", XLEN'(s_core_rvalid), XLEN'(x_crv));
        chk("dbg_rvalid",  XLEN'(s_dbg_rvalid),  XLEN'(x_drv));
        chk("core_rdata",  s_core_rdata,         x_crv ? mem_rdata_i : '0);
        chk("dbg_rdata",   s_dbg_rdata,          x_drv ? mem_rdata_i : '0);
    endtask

    task automatic model_update();
        int len;
        if (rst_i) begin
            m_prio = 0; m_locked_left = 0; m_pend_vld = 0; m_pend_dbg = 0;
        end else begin
            m_pend_vld = (e_core && !core_we_i) || (e_dbg && !dbg_we_i);
            m_pend_dbg = e_dbg;
            if (e_core) m_prio = 1;
            if (e_dbg)  m_prio = 0;
            if (m_locked_left > 0) begin
                m_locked_left = dbg_req_i ? m_locked_left - 1 : 0;
                if (m_locked_left == 0) m_prio = 0;
            end else if (e_dbg) begin
                len = int'(dbg_len_i);
                m_locked_left = (len > MAX_BURST - 1) ? MAX_BURST - 1 : len;
            end
        end
    endtask

    // One clock: check at the falling edge, advance the model, cross the rising edge.
    task automatic cyc();
        @(negedge clk_i);
        model_check();
        model_update();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        core_req_i = 0; core_we_i = 0; core_be_i = 4'hF; core_addr_i = '0; core_wdata_i = '0;
        dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = '0; dbg_wdata_i = '0; dbg_len_i = 4'd0;
    endtask

    int cnt;

    initial begin
        m_prio = 0; m_locked_left = 0; m_pend_vld = 0; m_pend_dbg = 0;
        idle();
        mem_rdata_i = 32'h1234_5678;
        rst_i = 1;
        cyc();
        cyc();
        chk("reset_gnt",  XLEN'({s_core_gnt, s_dbg_gnt, s_mem_en}), '0);
        chk("reset_rval", XLEN'({s_core_rvalid, s_dbg_rvalid}), '0);
        rst_i = 0;

        // Core-only read.
        core_req_i = 1; core_addr_i = 32'h8000_0010;
        cyc();
        chk("core_only_gnt", XLEN'(s_core_gnt), 1);
        chk("core_only_addr", s_mem_addr, 32'h8000_0010);
        idle(); mem_rdata_i = 32'hDEAD_BEEF;
        cyc();
        chk("core_only_rvalid", XLEN'(s_core_rvalid), 1);
        chk("core_only_rdata", s_core_rdata, 32'hDEAD_BEEF);
        chk("core_only_dbg_rvalid", XLEN'(s_dbg_rvalid), 0);

        // Contention alternation right after reset.
        rst_i = 1; cyc(); rst_i = 0;
        core_req_i = 1; core_addr_i = 32'h0000_0100;
        dbg_req_i = 1; dbg_addr_i = 32'h0000_0200; dbg_len_i = 4'd0;
        for (int i = 0; i < 4; i++) begin
            mem_rdata_i = $urandom;
            cyc();
            chk("alt_core_gnt", XLEN'(s_core_gnt), XLEN'(i % 2 == 0));
            chk("alt_addr", s_mem_addr, (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
        end
        idle(); cyc();

        // Burst lock: a core write first so debug is favoured, then len=3 against the core.
        core_req_i = 1; core_we_i = 1; core_addr_i = 32'h40;
        cyc();
        core_we_i = 0; core_addr_i = 32'h44;
        dbg_req_i = 1; dbg_len_i = 4'd3; dbg_addr_i = 32'h80;
        for (int i = 0; i < 4; i++) begin
            mem_rdata_i = $urandom;
            cyc();
            chk("burst_dbg_gnt", XLEN'(s_dbg_gnt), 1);
            chk("burst_stall", XLEN'(s_core_stall), 1);
        end
        cyc();
        chk("burst_core_after", XLEN'(s_core_gnt), 1);

        // Clamp: len=15 with core waiting, debug favoured after the last core grant.
        cnt = 0;
        dbg_len_i = 4'd15;
        for (int i = 0; i < 8; i++) begin
            mem_rdata_i = $urandom;
            cyc();
            if (s_dbg_gnt) cnt++;
        end
        chk("clamp_beats", XLEN'(cnt), 8);
        cyc();
        chk("clamp_core_after", XLEN'(s_core_gnt), 1);

        // Abort: len=5, two beats then drop the debug request.
        dbg_len_i = 4'd5;
        cyc(); chk("abort_beat1", XLEN'(s_dbg_gnt), 1);
        cyc(); chk("abort_beat2", XLEN'(s_dbg_gnt), 1);
        dbg_req_i = 0;
        cyc(); chk("abort_no_gnt", XLEN'({s_core_gnt, s_dbg_gnt}), 0);
        cyc(); chk("abort_core_next", XLEN'(s_core_gnt), 1);
        idle(); cyc();

        // Core store path.
        core_req_i = 1; core_we_i = 1; core_be_i = 4'b0011; core_wdata_i = 32'h0000_ABCD;
        cyc();
        chk("wr_we", XLEN'(s_mem_we), 1);
        chk("wr_be", XLEN'(s_mem_be), 4'b0011);
        chk("wr_wdata", s_mem_wdata, 32'h0000_ABCD);
        idle(); cyc();
        chk("wr_no_rvalid", XLEN'({s_core_rvalid, s_dbg_rvalid}), 0);

        // Reset while a debug read is outstanding.
        dbg_req_i = 1; dbg_addr_i = 32'h300; dbg_len_i = 4'd0;
        cyc();
        chk("rstrd_gnt", XLEN'(s_dbg_gnt), 1);
        idle(); rst_i = 1; mem_rdata_i = 32'hCAFE_F00D;
        cyc();
        chk("rstrd_rvalid", XLEN'(s_dbg_rvalid), 0);
        rst_i = 0;
        cyc();
        chk("rstrd_rvalid_after", XLEN'(s_dbg_rvalid), 0);
        core_req_i = 1; dbg_req_i = 1;
        cyc();
        chk("rstrd_core_first", XLEN'(s_core_gnt), 1);
        idle(); cyc();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rst_i        = ($urandom_range(0, 63) == 0);
            core_req_i   = ($urandom_range(0, 3) != 0);
            core_we_i    = $urandom_range(0, 1);
            core_be_i    = 4'($urandom);
            core_addr_i  = $urandom;
            core_wdata_i = $urandom;
            dbg_req_i    = ($urandom_range(0, 4) != 0);
            dbg_we_i     = $urandom_range(0, 1);
            dbg_addr_i   = $urandom;
            dbg_wdata_i  = $urandom;
            dbg_len_i    = 4'($urandom);
            mem_rdata_i  = $urandom;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
